// File: rtl/compare_serial_64.sv
// Serial set-less-than unit: scans two XLEN operands one DIGIT per cycle from the
// most significant end and reports the SLT/SLTU result on a valid/ready channel.
module compare_serial_64 #(
  parameter int XLEN  = 64,
  parameter int DIGIT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            is_unsigned,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int NDIG = XLEN / DIGIT;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [XLEN-1:0]   a, b;
  logic [IDXW-1:0]   idx;
  logic              lt;
  logic [XLEN-1:0]   sign_mask;
  logic [DIGIT-1:0]  a_dig [NDIG];
  logic [DIGIT-1:0]  b_dig [NDIG];
  logic              digit_lt;
  logic              digit_ne;
  logic              scan_end;

  // Flipping the sign bit maps signed order onto unsigned order.
  assign sign_mask = {~is_unsigned, {(XLEN-1){1'b0}}};

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
    assign a_dig[gi] = a[gi*DIGIT +: DIGIT];
    assign b_dig[gi] = b[gi*DIGIT +: DIGIT];
  end

  assign digit_lt = a_dig[idx] < b_dig[idx];
  assign digit_ne = a_dig[idx] != b_dig[idx];
  assign scan_end = digit_ne || (idx == '0);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = SCAN;
      SCAN:    if (scan_end) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a   <= '0;
      b   <= '0;
      idx <= '0;
      lt  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a   <= rs1 ^ sign_mask;
            b   <= rs2 ^ sign_mask;
            idx <= IDXW'(NDIG - 1);
          end
        end
        SCAN: begin
          // On the last digit with equal operands digit_lt is already 0.
          if (scan_end) begin
            lt <= digit_lt;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // lt only changes on DONE entry (or reset), so result is stable through DONE and IDLE.
  assign result    = {{(XLEN-1){1'b0}}, lt};
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
